wb_cmd_master: RTL and testbench
================================

// Module: wb_cmd_master
// PURPOSE
//  Single-outstanding Wishbone pipelined master sitting directly upstream of one wishbone_RAM port.
//  Converts a valid/ready command stream (byte or word, read or write) into one bus cycle.
//  Returns read data / status on a valid/ready response stream; honours stall and ack.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles cyc_o may stay high waiting for ack (WB_TIMEOUT_EN only), 1..65535
// PORTS
//  clk         in   1   single clock, all logic on rising edge
//  rst         in   1   synchronous, active-low reset (0 = reset)
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   master idle; command accepted on valid&ready edge
//  cmd_we      in   1   1 = write, 0 = read
//  cmd_size    in   1   0 = byte, 1 = word
//  cmd_addr    in   13  byte address; word access ignores [1:0]
//  cmd_wdata   in   32  write data; byte writes use [7:0] only
//  rsp_valid   out  1   response present, held until rsp_ready
//  rsp_ready   in   1   consumer accepts response
//  rsp_rdata   out  32  read data (byte reads zero-extended from [7:0]); 0 for writes
//  rsp_err     out  1   1 = bus timeout (tied 0 without WB_TIMEOUT_EN)
//  wb_addr_o   out  11  word address = cmd_addr[12:2]
//  wb_data_o   out  32  write data
//  wb_data_i   in   32  read data from slave
//  wb_we_o     out  1   write enable
//  wb_sel_o    out  4   byte: 1<<cmd_addr[1:0]; word: 4'b1111
//  wb_stb_o    out  1   request strobe
//  wb_cyc_o    out  1   bus cycle active
//  wb_ack_i    in   1   slave termination
//  wb_stall_i  in   1   slave cannot accept request this cycle
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0; asserting rst mid-cycle drops cyc/stb next
//   edge, discards in-flight command, no response emitted; late ack after reset ignored.
//  FSM: IDLE -> REQ -> WAIT_ACK -> RESP -> IDLE; all bus/rsp outputs registered.
//  IDLE: cmd_ready=1. On cmd_valid edge latch fields; next cycle REQ with cyc=stb=1.
//  Byte convention: byte write drives wb_data_o={24'b0,cmd_wdata[7:0]}, lane via sel only;
//   slave steers lanes. Byte read returns {24'b0,wb_data_i[7:0]}.
//  REQ: stb, addr, data, we, sel held stable while wb_stall_i=1.
//   Edge with stb&!stall: request taken; stb->0. If ack also high same edge -> RESP, else WAIT_ACK.
//  WAIT_ACK: cyc=1, stb=0; on ack capture wb_data_i (reads) -> RESP, cyc->0.
//  ack while in IDLE/RESP ignored. ack in REQ with stall=1 ignored.
//  RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready edge -> IDLE.
//   rsp_ready asserted early has no effect; cmd_ready stays 0 until back in IDLE.
//  Min latency (no stall, ack next cycle): cmd accept edge N, stb high N+1, ack N+2,
//   rsp_valid N+3; back-to-back throughput 1 command / 4 cycles.
//  Write response: rsp_rdata=0, rsp_err=0.
// CONFIGURATION
//  WB_TIMEOUT_EN defined: 16-bit counter cleared on entering REQ, increments each cycle in
//   REQ/WAIT_ACK; reaching TIMEOUT_CYCLES with no ack -> cyc=stb=0, RESP with rsp_err=1,
//   rsp_rdata=0. Counter saturates, never wraps.
//  WB_TIMEOUT_EN undefined: no counter, waits for ack indefinitely, rsp_err constant 0.
// TESTING
//  1 Reset: rst=0 two cycles -> cmd_ready, cyc, stb, rsp_valid all 0; rst=1 -> cmd_ready=1.
//  2 Byte write A5 @0x0007, then byte read @0x0007 -> wb_addr_o=0x001, wb_sel_o=4'b1000,
//    wb_data_o=0x000000A5; rsp_rdata=0x000000A5, rsp_err=0.
//  3 Word write 0xDEADBEEF @0x1FFC, word read back -> wb_addr_o=0x7FF, sel=4'b1111,
//    rsp_rdata=0xDEADBEEF; rsp_valid 3 cycles after accept.
//  4 Stall 5 cycles on word read @0x0040 -> stb/addr/sel stable 5 cycles, single transfer,
//    correct data; rsp_ready held 0 for 3 cycles -> rsp_valid/rdata held, cmd_ready=0.
//  5 rst=0 in WAIT_ACK, slave acks next cycle -> no rsp_valid, cyc=0, cmd_ready=1 after rst=1.
//  6 WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 cycles,
//    rsp_err=1, rsp_rdata=0; without macro cyc stays high 100+ cycles.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone pipelined master: one valid/ready command becomes one bus cycle.
// Optional macro WB_TIMEOUT_EN aborts a cycle with rsp_err after TIMEOUT_CYCLES cycles without ack.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic        cmd_size,
    input  logic [12:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [10:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, RESP} state_t;

    state_t      state_q, state_d;
    logic        size_q, size_d;
    logic        cmd_ready_d;
    logic        rsp_valid_d, rsp_err_d;
    logic [31:0] rsp_rdata_d;
    logic [10:0] wb_addr_d;
    logic [31:0] wb_data_d;
    logic        wb_we_d, wb_stb_d, wb_cyc_d;
    logic [3:0]  wb_sel_d;
    logic        ack_ok;
    logic        tmo_hit;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("wb_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
    end

`ifdef WB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;

    // Held at zero while idle so it starts from zero on entry to REQ; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst || state_q == IDLE) begin
            tmo_cnt <= '0;
        end else if ((state_q == REQ || state_q == WAIT_ACK) && tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (state_q == REQ || state_q == WAIT_ACK) && (tmo_cnt >= TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // An ack only terminates the cycle once the request itself has been taken.
    assign ack_ok = wb_ack_i && (state_q == WAIT_ACK || (state_q == REQ && !wb_stall_i));

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        wb_addr_d   = wb_addr_o;
        wb_data_d   = wb_data_o;
        wb_we_d     = wb_we_o;
        wb_sel_d    = wb_sel_o;
        wb_stb_d    = wb_stb_o;
        wb_cyc_d    = wb_cyc_o;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d   = REQ;
                    size_d    = cmd_size;
                    wb_addr_d = cmd_addr[12:2];
                    wb_data_d = cmd_size ? cmd_wdata : {24'b0, cmd_wdata[7:0]};
                    wb_we_d   = cmd_we;
                    wb_sel_d  = cmd_size ? 4'b1111 : (4'b0001 << cmd_addr[1:0]);
                    wb_stb_d  = 1'b1;
                    wb_cyc_d  = 1'b1;
                end
            end
            REQ, WAIT_ACK: begin
                if (ack_ok) begin
                    state_d     = RESP;
                    wb_stb_d    = 1'b0;
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = wb_we_o ? '0 : (size_q ? wb_data_i : {24'b0, wb_data_i[7:0]});
                end else if (tmo_hit) begin
                    state_d     = RESP;
                    wb_stb_d    = 1'b0;
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (state_q == REQ && !wb_stall_i) begin
                    state_d  = WAIT_ACK;
                    wb_stb_d = 1'b0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            size_q    <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wb_addr_o <= '0;
            wb_data_o <= '0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            wb_addr_o <= wb_addr_d;
            wb_data_o <= wb_data_d;
            wb_we_o   <= wb_we_d;
            wb_sel_o  <= wb_sel_d;
            wb_stb_o  <= wb_stb_d;
            wb_cyc_o  <= wb_cyc_d;
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master against a small pipelined Wishbone RAM model.
// Byte reads from the model carry junk in [31:8] so the master's zero-extension is exercised.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we, cmd_size;
    logic [12:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [10:0] wb_addr_o;
    logic [31:0] wb_data_o, wb_data_i;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
    logic [3:0]  wb_sel_o;

    logic        stall = 1'b0;
    logic        hold_ack = 1'b0;
    logic        force_ack = 1'b0;
    logic        s_ack;
    logic [31:0] s_rdata = '0;
    logic [31:0] mem [0:2047];
    int          xfer_cnt = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign wb_ack_i  = s_ack | force_ack;
    assign wb_data_i = s_rdata;

    wb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_size   (cmd_size),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_data_i  (wb_data_i),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_ack_i   (wb_ack_i),
        .wb_stall_i (stall)
    );

    // Slave: takes a request on stb&!stall, acks one cycle later, byte lanes steered via [7:0].
    always @(posedge clk) begin
        if (!rst) begin
            s_ack <= 1'b0;
        end else begin
            s_ack <= 1'b0;
            if (wb_cyc_o && wb_stb_o && !stall) begin
                xfer_cnt <= xfer_cnt + 1;
                if (!hold_ack) s_ack <= 1'b1;
                if (wb_we_o) begin
                    if (wb_sel_o == 4'b1111) mem[wb_addr_o] <= wb_data_o;
                    else for (int b = 0; b < 4; b++)
                        if (wb_sel_o[b]) mem[wb_addr_o][b*8 +: 8] <= wb_data_o[7:0];
                end else begin
                    if (wb_sel_o == 4'b1111) s_rdata <= mem[wb_addr_o];
                    else for (int b = 0; b < 4; b++)
                        if (wb_sel_o[b]) s_rdata <= {24'hC35A3C, mem[wb_addr_o][b*8 +: 8]};
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic we, input logic size, input logic [12:0] addr,
                         input logic [31:0] wdata);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_size  = size;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rsp_wait: rsp_valid=%b required 1 within 200 cycles", rsp_valid);
        end
    endtask

    task automatic take_rsp;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rsp_done: {rsp_valid,cmd_ready}=%b required 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, wb_cyc_o, wb_stb_o, rsp_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outs: {cmd_ready,cyc,stb,rsp_valid}=%b required 0000",
                     {cmd_ready, wb_cyc_o, wb_stb_o, rsp_valid});
        end
        checks++;
        if ({rsp_rdata, rsp_err, wb_sel_o, wb_we_o} !== 38'b0) begin
            failures++;
            $display("FAIL reset_data: rdata=%h err=%b sel=%b we=%b required all 0",
                     rsp_rdata, rsp_err, wb_sel_o, wb_we_o);
        end
        cmd_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_byte;
        int lat;
        issue(1'b1, 1'b1, 13'h0004, 32'h11223344);
        wait_rsp(lat);
        take_rsp();

        issue(1'b1, 1'b0, 13'h0007, 32'hFFFFFFA5);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o} !== {3'b111, 11'h001, 4'b1000}) begin
            failures++;
            $display("FAIL bw_bus: cyc/stb/we=%b addr=%h sel=%b required 111 001 1000",
                     {wb_cyc_o, wb_stb_o, wb_we_o}, wb_addr_o, wb_sel_o);
        end
        checks++;
        if (wb_data_o !== 32'h000000A5) begin
            failures++;
            $display("FAIL bw_data: wb_data_o=%h required 000000a5", wb_data_o);
        end
        wait_rsp(lat);
        checks++;
        if ({rsp_rdata, rsp_err} !== 33'h0) begin
            failures++;
            $display("FAIL bw_rsp: rdata=%h err=%b required 0 0", rsp_rdata, rsp_err);
        end
        take_rsp();

        issue(1'b0, 1'b0, 13'h0007, 32'hFFFFFFFF);
        checks++;
        if ({wb_we_o, wb_addr_o, wb_sel_o} !== {1'b0, 11'h001, 4'b1000}) begin
            failures++;
            $display("FAIL br_bus: we=%b addr=%h sel=%b required 0 001 1000",
                     wb_we_o, wb_addr_o, wb_sel_o);
        end
        wait_rsp(lat);
        checks++;
        if ({rsp_rdata, rsp_err} !== {32'h000000A5, 1'b0}) begin
            failures++;
            $display("FAIL br_rsp: rdata=%h err=%b required 000000a5 0", rsp_rdata, rsp_err);
        end
        take_rsp();

        issue(1'b0, 1'b1, 13'h0004, 32'h0);
        wait_rsp(lat);
        checks++;
        if (rsp_rdata !== 32'hA5223344) begin
            failures++;
            $display("FAIL lane_word: rdata=%h required a5223344", rsp_rdata);
        end
        take_rsp();

        issue(1'b0, 1'b0, 13'h0005, 32'h0);
        checks++;
        if (wb_sel_o !== 4'b0010) begin
            failures++;
            $display("FAIL lane1_sel: sel=%b required 0010", wb_sel_o);
        end
        wait_rsp(lat);
        checks++;
        if (rsp_rdata !== 32'h00000033) begin
            failures++;
            $display("FAIL lane1_rsp: rdata=%h required 00000033", rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_word;
        int lat;
        issue(1'b1, 1'b1, 13'h1FFC, 32'hDEADBEEF);
        checks++;
        if ({wb_addr_o, wb_sel_o, wb_data_o} !== {11'h7FF, 4'b1111, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL ww_bus: addr=%h sel=%b data=%h required 7ff 1111 deadbeef",
                     wb_addr_o, wb_sel_o, wb_data_o);
        end
        wait_rsp(lat);
        take_rsp();

        issue(1'b0, 1'b1, 13'h1FFF, 32'h0);
        checks++;
        if ({wb_addr_o, wb_sel_o} !== {11'h7FF, 4'b1111}) begin
            failures++;
            $display("FAIL wr_bus: addr=%h sel=%b required 7ff 1111", wb_addr_o, wb_sel_o);
        end
        wait_rsp(lat);
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL wr_latency: rsp_valid after %0d cycles required 3", lat);
        end
        checks++;
        if ({rsp_rdata, rsp_err} !== {32'hDEADBEEF, 1'b0}) begin
            failures++;
            $display("FAIL wr_rsp: rdata=%h err=%b required deadbeef 0", rsp_rdata, rsp_err);
        end
        take_rsp();
    endtask

    task automatic test_stall;
        int lat, base;
        issue(1'b1, 1'b1, 13'h0040, 32'hCAFEF00D);
        wait_rsp(lat);
        take_rsp();

        stall = 1'b1;
        base  = xfer_cnt;
        issue(1'b0, 1'b1, 13'h0040, 32'h0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({wb_cyc_o, wb_stb_o, wb_addr_o, wb_sel_o, rsp_valid} !==
                {2'b11, 11'h010, 4'b1111, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold%0d: cyc/stb=%b addr=%h sel=%b rsp_valid=%b required 11 010 1111 0",
                         i, {wb_cyc_o, wb_stb_o}, wb_addr_o, wb_sel_o, rsp_valid);
            end
            force_ack = (i == 1);
            if (i == 4) stall = 1'b0;
            @(negedge clk);
        end
        force_ack = 1'b0;
        wait_rsp(lat);
        checks++;
        if (xfer_cnt - base != 1) begin
            failures++;
            $display("FAIL stall_xfers: %0d transfers required 1", xfer_cnt - base);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rsp_valid, cmd_ready, rsp_err, rsp_rdata} !== {3'b100, 32'hCAFEF00D}) begin
                failures++;
                $display("FAIL rsp_hold%0d: valid/ready/err=%b rdata=%h required 100 cafef00d",
                         i, {rsp_valid, cmd_ready, rsp_err}, rsp_rdata);
            end
            @(negedge clk);
        end
        take_rsp();
    endtask

    task automatic test_reset_in_flight;
        int lat;
        bit seen;
        hold_ack = 1'b1;
        issue(1'b0, 1'b1, 13'h0040, 32'h0);
        @(negedge clk);
        checks++;
        if ({wb_cyc_o, wb_stb_o} !== 2'b10) begin
            failures++;
            $display("FAIL wait_ack_state: cyc/stb=%b required 10", {wb_cyc_o, wb_stb_o});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_outs: cyc/stb/rsp_valid/cmd_ready=%b required 0000",
                     {wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready});
        end
        force_ack = 1'b1;
        hold_ack  = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        checks++;
        if ({cmd_ready, wb_cyc_o} !== 2'b10) begin
            failures++;
            $display("FAIL midrst_ready: cmd_ready/cyc=%b required 10", {cmd_ready, wb_cyc_o});
        end
        seen = 1'b0;
        repeat (4) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL late_ack: rsp_valid seen=1 required 0");
        end
        issue(1'b0, 1'b1, 13'h0040, 32'h0);
        wait_rsp(lat);
        checks++;
        if (rsp_rdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL midrst_recover: rdata=%h required cafef00d", rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_back_to_back;
        int n, acc, rsp, bad, second;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_size  = 1'b1;
        cmd_addr  = 13'h1FFC;
        cmd_wdata = 32'h0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = 0; rsp = 0; bad = 0; second = -1;
        for (int c = 0; c < 12; c++) begin
            if (cmd_ready) begin
                acc++;
                if (acc == 2) second = c;
            end
            if (rsp_valid) begin
                rsp++;
                if (rsp_rdata !== 32'hDEADBEEF) bad++;
            end
            if (c == 11) cmd_valid = 1'b0;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        checks++;
        if (acc != 3 || second != 4) begin
            failures++;
            $display("FAIL b2b_accepts: accepts=%0d second_at=%0d required 3 and 4", acc, second);
        end
        checks++;
        if (rsp != 3 || bad != 0) begin
            failures++;
            $display("FAIL b2b_rsps: responses=%0d bad_data=%0d required 3 and 0", rsp, bad);
        end
    endtask

    task automatic test_timeout;
        int n;
        hold_ack = 1'b1;
        issue(1'b0, 1'b1, 13'h0040, 32'h0);
`ifdef WB_TIMEOUT_EN
        n = 0;
        while (wb_cyc_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL tmo_cycles: cyc high %0d cycles required 8", n);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
            failures++;
            $display("FAIL tmo_rsp: valid/err=%b rdata=%h required 11 00000000",
                     {rsp_valid, rsp_err}, rsp_rdata);
        end
        hold_ack = 1'b0;
        take_rsp();
`else
        n = 0;
        for (int c = 0; c < 120; c++) begin
            if (wb_cyc_o && !rsp_valid) n++;
            @(negedge clk);
        end
        checks++;
        if (n != 120) begin
            failures++;
            $display("FAIL no_tmo: cyc held %0d of 120 cycles required 120", n);
        end
        hold_ack = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, wb_cyc_o, rsp_valid} !== 3'b100) begin
            failures++;
            $display("FAIL no_tmo_recover: ready/cyc/rsp_valid=%b required 100",
                     {cmd_ready, wb_cyc_o, rsp_valid});
        end
`endif
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_size  = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_byte();
        test_word();
        test_stall();
        test_reset_in_flight();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
